// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, default
// encodings and the fetch FSM state type.
package instr_fetch_pkg;

   localparam int unsigned IM_ADDR_W = 14;
   localparam int unsigned INSTR_W   = 16;
   localparam int unsigned CNT_W     = 32;

   localparam logic [3:0]         HLT_OPCODE_DEF = 4'hF;
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEF  = 16'hB000;

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_perf_cnt.sv
// Saturating fetch/stall event counters for the fetch stage.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt
   import instr_fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_evt,
   input  logic             stall_evt,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]            evt;
   logic [1:0][CNT_W-1:0] cnt_vec;

   assign evt = {stall_evt, fetch_evt};

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Next count: bump on the event, stick at all-ones instead of wrapping.
      always_comb begin
         cnt_d = cnt_q;
         if (evt[gi] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Counter register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_vec[gi] = cnt_q;
   end

   assign fetch_cnt = cnt_vec[0];
   assign stall_cnt = cnt_vec[1];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// (which reads on negedge) and captures into the IF/ID register on posedge.
// Optional performance counters are enabled with macro FETCH_PERF_CNT_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [IM_ADDR_W-1:0] RESET_PC   = 14'h0000,
   parameter logic [3:0]           HLT_OPCODE = HLT_OPCODE_DEF,
   parameter logic [INSTR_W-1:0]   NOP_INSTR  = NOP_INSTR_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [IM_ADDR_W-1:0] br_target,
   output logic [IM_ADDR_W-1:0] im_addr,
   output logic                 im_rd_en,
   input  logic [INSTR_W-1:0]   im_instr,
   output logic [INSTR_W-1:0]   if_id_instr,
   output logic [IM_ADDR_W-1:0] if_id_pc,
   output logic                 if_id_vld,
   output logic                 halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     fetch_cnt,
   output logic [CNT_W-1:0]     stall_cnt
`endif
);

   fetch_state_e         state_q, state_d;
   logic [IM_ADDR_W-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [IM_ADDR_W-1:0] ifpc_q, ifpc_d;
   logic                 vld_q, vld_d;
   logic                 halted_q, halted_d;

   // Next-state and IF/ID update: flush beats stall beats capture.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      ifpc_d   = ifpc_q;
      vld_d    = vld_q;
      halted_d = halted_q;
      unique case (state_q)
         ST_PRIME: begin
            // Give the memory one negedge to present pc before capturing.
            state_d = ST_RUN;
            if (flush) begin
               pc_d = br_target;
            end
         end
         ST_RUN: begin
            if (flush) begin
               pc_d    = br_target;
               instr_d = NOP_INSTR;
               vld_d   = 1'b0;
            end else if (!stall) begin
               instr_d = im_instr;
               ifpc_d  = pc_q + 1'b1;
               vld_d   = 1'b1;
               pc_d    = pc_q + 1'b1;
               if (im_instr[INSTR_W-1 -: 4] == HLT_OPCODE) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end
            end
         end
         ST_HALT: begin
            // The HLT word was valid for one cycle; squash from here on.
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
            if (flush) begin
               pc_d     = br_target;
               halted_d = 1'b0;
               state_d  = ST_RUN;
            end
         end
         default: begin
            state_d = ST_PRIME;
         end
      endcase
   end

   // State, PC and IF/ID registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_PRIME;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         ifpc_q   <= '0;
         vld_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         ifpc_q   <= ifpc_d;
         vld_q    <= vld_d;
         halted_q <= halted_d;
      end
   end

   assign im_addr     = pc_q;
   assign im_rd_en    = (state_q != ST_HALT);
   assign if_id_instr = instr_q;
   assign if_id_pc    = ifpc_q;
   assign if_id_vld   = vld_q;
   assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
   logic fetch_evt;
   logic stall_evt;

   assign fetch_evt = (state_q == ST_RUN) && !flush && !stall;
   assign stall_evt = (state_q == ST_RUN) && !flush && stall;

   fetch_perf_cnt u_perf (
      .clk       (clk),
      .rst_n     (rst_n),
      .fetch_evt (fetch_evt),
      .stall_evt (stall_evt),
      .fetch_cnt (fetch_cnt),
      .stall_cnt (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural negedge instruction
// memory. Expected IF/ID contents are queued per step and compared 1 ns
// after the capturing posedge. Counter checks run when FETCH_PERF_CNT_EN is set.
module tb_instr_fetch;

   localparam logic [15:0] NOP = 16'hB000;

   typedef struct packed {
      logic        vld;
      logic [15:0] instr;
      logic [13:0] pc;
      logic [13:0] addr;
      logic        halted;
      logic        rd_en;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [13:0] br_target = '0;
   logic [13:0] im_addr;
   logic        im_rd_en;
   logic [15:0] im_instr = '0;
   logic [15:0] if_id_instr;
   logic [13:0] if_id_pc;
   logic        if_id_vld;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   logic [15:0] mem [16384];
   exp_t        sb_q [$];
   int          checks = 0;
   int          failures = 0;
   int          step_no = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .flush       (flush),
      .br_target   (br_target),
      .im_addr     (im_addr),
      .im_rd_en    (im_rd_en),
      .im_instr    (im_instr),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc),
      .if_id_vld   (if_id_vld),
      .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory: registered read on negedge, holds when disabled.
   always @(negedge clk) begin
      if (im_rd_en) im_instr <= mem[im_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t mk(input logic v, input logic [15:0] ins, input logic [13:0] p,
                               input logic [13:0] a, input logic h, input logic r);
      exp_t e;
      e.vld = v; e.instr = ins; e.pc = p; e.addr = a; e.halted = h; e.rd_en = r;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s step=%0d obs=%h exp=%h", tag, step_no, obs, exp);
      end
   endtask

   // Pop one expectation and compare against the present DUT outputs.
   task automatic compare_head();
      exp_t e;
      e = sb_q.pop_front();
      chk("vld",    {31'd0, if_id_vld},   {31'd0, e.vld});
      chk("instr",  {16'd0, if_id_instr}, {16'd0, e.instr});
      chk("if_pc",  {18'd0, if_id_pc},    {18'd0, e.pc});
      chk("addr",   {18'd0, im_addr},     {18'd0, e.addr});
      chk("halted", {31'd0, halted},      {31'd0, e.halted});
      chk("rd_en",  {31'd0, im_rd_en},    {31'd0, e.rd_en});
      $display("step %0d: vld=%0b instr=%h if_pc=%h addr=%h halted=%0b rd_en=%0b",
               step_no, if_id_vld, if_id_instr, if_id_pc, im_addr, halted, im_rd_en);
      step_no++;
   endtask

   // Drive inputs for one cycle, queue the expected result, check after the edge.
   task automatic step(input logic s, input logic f, input logic [13:0] tgt, input exp_t e);
      stall = s; flush = f; br_target = tgt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   task automatic tick(input logic s, input logic f);
      stall = s; flush = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = {4'h5, i[11:0]};
      mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

      // Reset state
      @(posedge clk); #1;
      step(0, 0, 14'h0, mk(0, NOP, 14'h0, 14'h0, 0, 1));
      rst_n = 1'b1;

      // PRIME then straight-line fetch
      step(0, 0, 14'h0, mk(0, NOP, 14'h0, 14'h0, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h1111, 14'h1, 14'h1, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h2222, 14'h2, 14'h2, 0, 1));
      // Stall three cycles holding 2222
      for (int i = 0; i < 3; i++) step(1, 0, 14'h0, mk(1, 16'h2222, 14'h2, 14'h2, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h3333, 14'h3, 14'h3, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h4444, 14'h4, 14'h4, 0, 1));

      // Flush together with stall: flush wins
      step(1, 1, 14'h0100, mk(0, NOP, 14'h4, 14'h0100, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h5100, 14'h0101, 14'h0101, 0, 1));

      // HLT at word 2
      mem[2] = 16'hF000;
      step(0, 1, 14'h0, mk(0, NOP, 14'h0101, 14'h0, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h1111, 14'h1, 14'h1, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h2222, 14'h2, 14'h2, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'hF000, 14'h3, 14'h3, 1, 0));
      for (int i = 0; i < 3; i++) step(0, 0, 14'h0, mk(0, NOP, 14'h3, 14'h3, 1, 0));
      // Restart from halt
      step(0, 1, 14'h0, mk(0, NOP, 14'h3, 14'h0, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h1111, 14'h1, 14'h1, 0, 1));

      // PC wrap at top of memory
      step(0, 1, 14'h3FFF, mk(0, NOP, 14'h1, 14'h3FFF, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h5FFF, 14'h0, 14'h0, 0, 1));
      step(0, 0, 14'h0, mk(1, 16'h1111, 14'h1, 14'h1, 0, 1));

      // Asynchronous reset mid-cycle takes effect without a clock edge
      #2 rst_n = 1'b0;
      #1;
      sb_q.push_back(mk(0, NOP, 14'h0, 14'h0, 0, 1));
      compare_head();
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem[2] = 16'h3333;

`ifdef FETCH_PERF_CNT_EN
      tick(0, 0);                                   // PRIME, not counted
      for (int i = 0; i < 10; i++) tick(0, 0);
      for (int i = 0; i < 4; i++) tick(1, 0);
      tick(1, 1);                                   // flush+stall counts as neither
      stall = 0; flush = 0;
      chk("fetch_cnt", fetch_cnt, 32'd10);
      chk("stall_cnt", stall_cnt, 32'd4);
      $display("perf: fetch_cnt=%0d stall_cnt=%0d", fetch_cnt, stall_cnt);
      #2 rst_n = 1'b0;
      #1;
      chk("fetch_cnt_rst", fetch_cnt, 32'd0);
      chk("stall_cnt_rst", stall_cnt, 32'd0);
      $display("perf after reset: fetch_cnt=%0d stall_cnt=%0d", fetch_cnt, stall_cnt);
      rst_n = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that sits directly upstream of the 16-bit-wide instruction memory (14-bit word address, read flopped on negedge clk, output held while its read enable is low).
- Owns the PC and drives the memory's address and read enable.
- Captures the returned instruction into the IF/ID pipeline register on posedge, with valid, stall, flush/redirect and halt handling.

Parameters:
- RESET_PC, 14'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, instr[15:12] value that halts fetch.
- NOP_INSTR, 16'hB000, encoding inserted into IF/ID on flush.

Ports:
- clk  in  1  system clock; memory samples on negedge, this block on posedge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and IF/ID contents this cycle.
- flush  in  1  redirect: load br_target, squash IF/ID.
- br_target  in  14  redirect address, valid when flush=1.
- im_addr  out  14  instruction memory word address (equals the PC register).
- im_rd_en  out  1  instruction memory read enable.
- im_instr  in  16  instruction memory read data.
- if_id_instr  out  16  captured instruction.
- if_id_pc  out  14  PC+1 of the captured instruction.
- if_id_vld  out  1  if_id_instr is a real fetched instruction.
- halted  out  1  fetch stopped on HLT.

Behaviour:
- States: PRIME, RUN, HALT.
- Reset values: state=PRIME, pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_vld=0, halted=0.
- Reset mid-operation returns to exactly these values immediately (asynchronous).
- im_addr = pc register, driven combinationally from the flop.
- im_rd_en = 1 in PRIME and RUN, 0 in HALT. im_rd_en is never gated by stall: re-reading the held PC is harmless and keeps im_instr coherent with pc.
- PRIME: one posedge with no capture. pc holds, vld stays 0. Next state RUN. This guarantees im_instr reflects pc before the first capture.
- RUN, posedge, priority order:
  1. flush: pc<=br_target; if_id_instr<=NOP_INSTR; if_id_vld<=0; state stays RUN.
  2. stall: pc and all if_id_* hold.
  3. Otherwise: if_id_instr<=im_instr; if_id_pc<=pc+1; if_id_vld<=1; pc<=pc+1. The PC wraps modulo 2^14 (14'h3FFF -> 14'h0000).
- HLT capture: if a capture loads im_instr[15:12]==HLT_OPCODE, then at the same edge state<=HALT and halted<=1. pc still increments. The HLT word is presented valid for that one cycle.
- HALT: pc holds. At the next posedge, if_id_vld<=0 and if_id_instr<=NOP_INSTR; both hold thereafter.
- flush in HALT: pc<=br_target; halted<=0; state<=RUN. The memory reads the target on the intervening negedge, so the next posedge captures it.
- flush in PRIME: pc<=br_target; state<=RUN.
- flush and stall together: flush wins.
- Latency: the instruction at PC A is presented on if_id_* one cycle after pc==A with no stall.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] (increments per capture) and stall_cnt[31:0] (increments per RUN cycle with stall=1 and flush=0).
  - Both are reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - fetch state encoding (PRIME/RUN/HALT);
  - HLT_OPCODE and NOP_INSTR defaults;
  - IM_ADDR_W=14 and INSTR_W=16.
- One natural sub-module: fetch_perf_cnt, holding the saturating counters, instantiated only under FETCH_PERF_CNT_EN.
- PC and IF/ID logic stay inline.

Test Plan:
- Reset release with memory words 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444.
  - Response: vld=0 for the PRIME cycle, then if_id_instr 1111/2222/3333 on consecutive cycles, with if_id_pc 1/2/3.
- stall high 3 cycles while if_id_instr=16'h2222.
  - Response: instr, if_id_pc and pc hold for 3 cycles; next capture is 16'h3333, with no skip and no duplicate.
- flush with br_target=14'h0100 asserted together with stall.
  - Response: next cycle vld=0 and instr=NOP_INSTR; the cycle after, the word at 0x100 with if_id_pc=14'h0101.
- Memory word 2 = 16'hF000.
  - Response: HLT presented valid one cycle, halted=1, im_rd_en=0, then vld=0 permanently.
  - Follow-up: a later flush to 0 restarts fetch and clears halted.
- PC forced to 14'h3FFF via flush.
  - Response: captures word 0x3FFF with if_id_pc=14'h0000, then fetches from address 0.
- With FETCH_PERF_CNT_EN defined: 10 unstalled fetches plus 4 stall cycles yields fetch_cnt=10 and stall_cnt=4.
  - Asynchronous reset mid-run clears both counters.
